uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame FSM with 3-point majority bit sampling.
// The PARITY state, parity accumulator and Par_err exist only when UART_RX_PARITY_EN is defined.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  Sampled_bit,
  output logic                  DeSerializer_EN,
  output logic                  Data_Valid,
  output logic                  Par_err,
  output logic                  Stp_err,
  output logic                  Busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  sampled_q, sampled_d;
  logic                  den_q, den_d;
  logic                  dv_q, dv_d;
  logic                  stp_err_q, stp_err_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_acc_q, par_acc_d;
  logic                  par_err_q, par_err_d;
`else
  logic                  unused_par;
`endif

  logic [PRESCALE_W-1:0] half;
  logic                  at_s0, at_s1, at_s2, at_dec, at_last;
  logic                  flags_clear;

  assign half    = presc_q >> 1;
  assign at_s0   = (edge_cnt_q == half - PRESCALE_W'(1));
  assign at_s1   = (edge_cnt_q == half);
  assign at_s2   = (edge_cnt_q == half + PRESCALE_W'(1));
  assign at_dec  = (edge_cnt_q == half + PRESCALE_W'(2));
  assign at_last = (edge_cnt_q == presc_q - PRESCALE_W'(1));

`ifdef UART_RX_PARITY_EN
  assign flags_clear = ~par_err_q & ~stp_err_q;
`else
  assign flags_clear = ~stp_err_q;
  assign unused_par  = PAR_EN ^ PAR_TYP;
`endif

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    presc_d    = presc_q;
    bit_cnt_d  = bit_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    sampled_d  = sampled_q;
    den_d      = 1'b0;
    dv_d       = 1'b0;
    stp_err_d  = stp_err_q;
`ifdef UART_RX_PARITY_EN
    par_acc_d  = par_acc_q;
    par_err_d  = par_err_q;
`endif
    if (state_q == S_IDLE) begin
      edge_cnt_d = '0;
      // The low cycle seen in IDLE is edge 0 of the start bit.
      if (!RX_IN) begin
        state_d    = S_START;
        edge_cnt_d = PRESCALE_W'(1);
        presc_d    = Prescale;
        bit_cnt_d  = '0;
        stp_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_acc_d  = 1'b0;
        par_err_d  = 1'b0;
`endif
      end
    end else begin
      edge_cnt_d = at_last ? '0 : edge_cnt_q + PRESCALE_W'(1);
      if (at_s0) s0_d = RX_IN;
      if (at_s1) s1_d = RX_IN;
      // Vote lands in the flop so it is stable during the decision cycle.
      if (at_s2) begin
        sampled_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
        den_d     = (state_q == S_DATA);
      end
      case (state_q)
        S_START: begin
          if (at_dec && sampled_q) begin
            state_d    = S_IDLE;
            edge_cnt_d = '0;
          end else if (at_last) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
`ifdef UART_RX_PARITY_EN
          if (at_dec) par_acc_d = par_acc_q ^ sampled_q;
`endif
          if (at_last) begin
            if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = PAR_EN ? S_PARITY : S_STOP;
`else
              state_d   = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (at_dec && (sampled_q != (par_acc_q ^ PAR_TYP))) par_err_d = 1'b1;
          if (at_last) state_d = S_STOP;
        end
`endif
        S_STOP: begin
          if (at_dec && !sampled_q) stp_err_d = 1'b1;
          if (at_last) begin
            state_d = S_IDLE;
            dv_d    = flags_clear;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      presc_q    <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      sampled_q  <= 1'b0;
      den_q      <= 1'b0;
      dv_q       <= 1'b0;
      stp_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      presc_q    <= presc_d;
      bit_cnt_q  <= bit_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      sampled_q  <= sampled_d;
      den_q      <= den_d;
      dv_q       <= dv_d;
      stp_err_q  <= stp_err_d;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= par_acc_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign Sampled_bit     = sampled_q;
  assign DeSerializer_EN = den_q;
  assign Data_Valid      = dv_q;
  assign Stp_err         = stp_err_q;
  assign Busy            = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign Par_err         = par_err_q;
`else
  assign Par_err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - frame-level model of uart_rx_frame_ctrl checked every cycle, plus pinned literals.
module tb_uart_rx_frame_ctrl;
  localparam int W  = 8;
  localparam int NC = 4096;

  logic       clk = 1'b0;
  logic       Rst, RX_IN, PAR_EN, PAR_TYP;
  logic [5:0] Prescale;
  logic       Sampled_bit, DeSerializer_EN, Data_Valid, Par_err, Stp_err, Busy;

  uart_rx_frame_ctrl #(.DATA_WIDTH(W), .PRESCALE_W(6)) dut (
    .Clk(clk), .Rst(Rst), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Sampled_bit(Sampled_bit), .DeSerializer_EN(DeSerializer_EN), .Data_Valid(Data_Valid),
    .Par_err(Par_err), .Stp_err(Stp_err), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus as driven per cycle, DUT outputs as observed per cycle, and model expectations.
  bit line_a[NC], rst_a[NC], pen_a[NC], ptyp_a[NC];
  int p_a[NC];
  bit busy_a[NC], den_a[NC], dv_a[NC], perr_a[NC], serr_a[NC], samp_a[NC];
  bit e_busy[NC], e_den[NC], e_dv[NC], e_perr[NC], e_serr[NC], e_samp[NC];

  int tests = 0;
  int fails = 0;
  int cfg_p = 8;
  bit cfg_pen = 1'b0, cfg_ptyp = 1'b0;
  int nlast;

  always @(negedge clk) begin
    if (cyc < NC) begin
      busy_a[cyc] = Busy;
      den_a[cyc]  = DeSerializer_EN;
      dv_a[cyc]   = Data_Valid;
      perr_a[cyc] = Par_err;
      serr_a[cyc] = Stp_err;
      samp_a[cyc] = Sampled_bit;
    end
  end

  task automatic tick(input bit rx, input bit r);
    @(posedge clk);
    #1;
    RX_IN    = rx;
    Rst      = r;
    Prescale = 6'(cfg_p);
    PAR_EN   = cfg_pen;
    PAR_TYP  = cfg_ptyp;
    if (cyc < NC) begin
      line_a[cyc] = rx;
      rst_a[cyc]  = r;
      p_a[cyc]    = cfg_p;
      pen_a[cyc]  = cfg_pen;
      ptyp_a[cyc] = cfg_ptyp;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                            input bit pbit, input bit sbit, input int max_ticks, output int t0);
    bit bits[$];
    int n;
    n = 0;
    t0 = -1;
    cfg_p = p;
    cfg_pen = pen;
    cfg_ptyp = ptyp;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(sbit);
    foreach (bits[b]) begin
      for (int k = 0; k < p; k++) begin
        if (max_ticks >= 0 && n >= max_ticks) return;
        tick(bits[b], 1'b0);
        if (t0 < 0) t0 = cyc;
        n++;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit maj(input int c);
    return (int'(line_a[c]) + int'(line_a[c + 1]) + int'(line_a[c + 2])) >= 2;
  endfunction

  // Event kinds: 0 sampled level, 1 strobe, 2 data valid, 3 parity flag level, 4 stop flag level.
  int ev_c[$];
  int ev_k[$];
  bit ev_v[$];

  task automatic add_ev(input int c, input int k, input bit v);
    ev_c.push_back(c);
    ev_k.push_back(k);
    ev_v.push_back(v);
  endtask

  task automatic set_level(input int k, input int from, input bit v);
    for (int c = from; c < NC; c++) begin
      if (k == 0) e_samp[c] = v;
      else if (k == 3) e_perr[c] = v;
      else e_serr[c] = v;
    end
  endtask

  // Walks the recorded line frame by frame: bit b of a frame starting at t0 occupies
  // cycles t0+b*P .. t0+b*P+P-1, is voted from its three middle cycles and is visible P/2+2 in.
  task automatic run_model();
    int t, t0, p, h, e, cut, bs, nb;
    bit v, x, pe, se;
    for (int c = 0; c < NC; c++) begin
      e_busy[c] = 0; e_den[c] = 0; e_dv[c] = 0; e_perr[c] = 0; e_serr[c] = 0; e_samp[c] = 0;
    end
    t = 0;
    while (t < nlast) begin
      if (rst_a[t]) begin
        set_level(0, t + 1, 1'b0);
        set_level(3, t + 1, 1'b0);
        set_level(4, t + 1, 1'b0);
        t++;
      end else if (line_a[t]) begin
        t++;
      end else begin
        t0 = t; p = p_a[t0]; h = p / 2;
        ev_c.delete(); ev_k.delete(); ev_v.delete();
        add_ev(t0 + 1, 3, 1'b0);
        add_ev(t0 + 1, 4, 1'b0);
        v = maj(t0 + h - 1);
        add_ev(t0 + h + 2, 0, v);
        if (v) begin
          e = t0 + h + 3;
        end else begin
          x = 1'b0;
          for (int i = 0; i < W; i++) begin
            bs = t0 + (i + 1) * p;
            v = maj(bs + h - 1);
            add_ev(bs + h + 2, 0, v);
            add_ev(bs + h + 2, 1, 1'b1);
            x ^= v;
          end
          nb = W + 1;
          pe = 1'b0;
`ifdef UART_RX_PARITY_EN
          if (pen_a[t0]) begin
            bs = t0 + nb * p;
            v = maj(bs + h - 1);
            add_ev(bs + h + 2, 0, v);
            pe = (v != (x ^ ptyp_a[t0]));
            if (pe) add_ev(bs + h + 3, 3, 1'b1);
            nb++;
          end
`endif
          bs = t0 + nb * p;
          v = maj(bs + h - 1);
          add_ev(bs + h + 2, 0, v);
          se = !v;
          if (se) add_ev(bs + h + 3, 4, 1'b1);
          if (!pe && !se) add_ev(bs + p, 2, 1'b1);
          e = bs + p;
        end
        cut = NC;
        for (int c = t0 + 1; c < e && c < NC; c++) begin
          if (rst_a[c]) begin
            cut = c;
            break;
          end
        end
        foreach (ev_c[i]) begin
          if (ev_c[i] <= cut && ev_c[i] < NC) begin
            if (ev_k[i] == 1) e_den[ev_c[i]] = 1'b1;
            else if (ev_k[i] == 2) e_dv[ev_c[i]] = 1'b1;
            else set_level(ev_k[i], ev_c[i], ev_v[i]);
          end
        end
        for (int c = t0 + 1; c < e && c <= cut && c < NC; c++) e_busy[c] = 1'b1;
        t = (cut < NC) ? cut : e;
      end
    end
  endtask

  task automatic collect(input int from, input int to, output logic [7:0] b, output int n);
    b = '0;
    n = 0;
    for (int c = from; c < to; c++) begin
      if (den_a[c]) begin
        if (n < 8) b[n] = samp_a[c];
        n++;
      end
    end
  endtask

  function automatic int count_ev(input int from, input int to, input bit strobe);
    int n;
    n = 0;
    for (int c = from; c <= to; c++) n += strobe ? int'(den_a[c]) : int'(dv_a[c]);
    return n;
  endfunction

  int tA, tB, tC, tD, tE, tF, tG1, tG2, tH, tR, tI, d1, d2, nbits;
  logic [7:0] got_b;
  logic [5:0] got_v, exp_v;

  initial begin
    Rst = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    line_a[0] = 1'b1; rst_a[0] = 1'b1; p_a[0] = 8;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    idle(5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, tA);   idle(5);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, tB);  idle(5);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, tC);  idle(5);
    cfg_p = 8; cfg_pen = 1'b0; cfg_ptyp = 1'b0;
    tick(1'b0, 1'b0); tD = cyc; tick(1'b0, 1'b0);           idle(20);
    send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, tE);  idle(5);
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, tF);  idle(5);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, tG1);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, tG2);  idle(5);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 36, tH);
    tick(1'b1, 1'b1); tR = cyc;                               idle(5);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, tI);   idle(10);
    nlast = cyc;
    @(negedge clk);
    #1;

    run_model();
    for (int c = 1; c <= nlast; c++) begin
      got_v = {busy_a[c], den_a[c], dv_a[c], perr_a[c], serr_a[c], samp_a[c]};
      exp_v = {e_busy[c], e_den[c], e_dv[c], e_perr[c], e_serr[c], e_samp[c]};
      tests++;
      if (got_v != exp_v) begin
        fails++;
        $display("FAIL model cycle %0d: busy/den/dv/perr/serr/samp got %b, expected %b", c, got_v, exp_v);
      end
    end

    check("reset_outputs", int'({busy_a[1], den_a[1], dv_a[1], perr_a[1], serr_a[1], samp_a[1]}), 0);
    check("a5_dv_at_80", int'(dv_a[tA + 80]), 1);
    check("a5_dv_not_79", int'(dv_a[tA + 79]), 0);
    collect(tA, tA + 80, got_b, nbits);
    check("a5_strobe_count", nbits, 8);
    check("a5_bits", int'(got_b), 8'hA5);
    check("a5_no_err", int'({perr_a[tA + 80], serr_a[tA + 80]}), 0);
`ifdef UART_RX_PARITY_EN
    check("3c_par_err", int'(perr_a[tB + 176]), 1);
    check("3c_bad_no_dv", count_ev(tB, tB + 180, 1'b0), 0);
    check("3c_good_dv", int'(dv_a[tC + 176]), 1);
    check("3c_good_par_clear", int'(perr_a[tC + 176]), 0);
`else
    check("3c_parity_ignored_dv", int'(dv_a[tB + 160]), 1);
    check("3c_parity0_as_stop", int'(serr_a[tC + 160]), 1);
    check("par_err_const", int'(perr_a[tB + 176]), 0);
`endif
    check("glitch_busy_hold", int'(busy_a[tD + 6]), 1);
    check("glitch_busy_fall", int'(busy_a[tD + 7]), 0);
    check("glitch_no_strobe", count_ev(tD, tD + 20, 1'b1) + count_ev(tD, tD + 20, 1'b0), 0);
    check("glitch_no_flags", int'({perr_a[tD + 7], serr_a[tD + 7]}), 0);
    check("stop0_stp_err", int'(serr_a[tE + 320]), 1);
    check("stop0_no_dv", count_ev(tE, tE + 325, 1'b0), 0);
    check("stp_err_holds", int'(serr_a[tF]), 1);
    check("stp_err_clears", int'(serr_a[tF + 1]), 0);
    d1 = -1; d2 = -1;
    for (int c = tG1; c < tG2 + 90; c++) begin
      if (dv_a[c]) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    check("b2b_first_dv", d1 - tG1, 80);
    check("b2b_dv_spacing", d2 - d1, 80);
    collect(tG2, tG2 + 80, got_b, nbits);
    check("b2b_ff_bits", int'(got_b), 8'hFF);
    check("rst_busy_before", int'(busy_a[tR]), 1);
    check("rst_outputs_zero", int'({busy_a[tR + 1], den_a[tR + 1], dv_a[tR + 1], perr_a[tR + 1],
                                     serr_a[tR + 1], samp_a[tR + 1]}), 0);
    check("rst_no_dv", count_ev(tH, tI, 1'b0), 0);
    collect(tI, tI + 80, got_b, nbits);
    check("post_rst_81_bits", int'(got_b), 8'h81);
    check("post_rst_81_dv", int'(dv_a[tI + 80]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
